// File: rtl/vec_hazard_scoreboard.sv
// vec_hazard_scoreboard
//   Load-use hazard detector for the vector pipeline. A pending bit is kept for
//   every vector register with an in-flight memory load: it is set when the
//   load issues and cleared when the load writes back. Decode is stalled when
//   an operand comes from a load whose data does not exist yet, when a new
//   load would overwrite a register that is still pending, or when the
//   outstanding-load limit is reached.
//   Optional feature macro: HAZARD_STATS_EN adds a saturating stall_cycles
//   counter output.
//
//   Handshake: the ID instruction is accepted (issue=1) in the cycle where
//   dec_valid=1, flush=0 and stall=0. stall/bubble are purely combinational,
//   so the decision is made in the same cycle the instruction is presented.
//   A write-back in the same cycle as a read is forwarded, so it never stalls.
module vec_hazard_scoreboard #(
   parameter int NREG    = 16,
   parameter int REG_W   = 4,
   parameter int MAX_OUT = 4,
   parameter int CNT_W   = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             dec_valid,
   input  logic [REG_W-1:0] dec_r2,
   input  logic [REG_W-1:0] dec_r3,
   input  logic [1:0]       dec_extndsel,
   input  logic             dec_is_load,
   input  logic [REG_W-1:0] dec_dest,
   input  logic             flush,
   input  logic             wb_valid,
   input  logic [REG_W-1:0] wb_dest,
   output logic             stall,
   output logic             bubble,
   output logic             issue,
   output logic [NREG-1:0]  pending,
   output logic [CNT_W-1:0] out_cnt,
   output logic [1:0]       state,
`ifdef HAZARD_STATS_EN
   output logic [31:0]      stall_cycles,
`endif
   output logic             wb_err
);

   localparam logic [1:0] ST_RUN       = 2'b00;
   localparam logic [1:0] ST_HOLD_RAW  = 2'b01;
   localparam logic [1:0] ST_HOLD_FULL = 2'b10;

   logic [NREG-1:0]  pending_q, pending_d;
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
   logic [1:0]       state_q, state_d;
   logic             wb_err_q, wb_err_d;

   logic [NREG-1:0]  wb_mask;
   logic [NREG-1:0]  pend_eff;
   logic [CNT_W-1:0] cnt_eff;
   logic             used2, used3;
   logic             wb_hit;
   logic             raw, waw, full;
   logic             load_tracked;
   logic             set_pend;

   // Hazard detection: pending view with the same-cycle write-back removed.
   always_comb begin
      wb_mask      = wb_valid ? (NREG'(1) << wb_dest) : '0;
      pend_eff     = pending_q & ~wb_mask;
      used2        = ~dec_extndsel[1];
      used3        = (dec_extndsel == 2'b00);
      wb_hit       = wb_valid & (wb_dest != '0) & pending_q[wb_dest];
      cnt_eff      = out_cnt_q - CNT_W'(wb_hit);
      load_tracked = dec_valid & dec_is_load & (dec_dest != '0);
      raw          = dec_valid & ((used2 & pend_eff[dec_r2]) | (used3 & pend_eff[dec_r3]));
      waw          = load_tracked & pend_eff[dec_dest];
      full         = load_tracked & (cnt_eff == CNT_W'(MAX_OUT));
      stall        = ~flush & (raw | waw | full);
      bubble       = stall;
      issue        = dec_valid & ~flush & ~stall;
      set_pend     = issue & dec_is_load & (dec_dest != '0);
   end

   // Next-state for tracking bits, outstanding count, error flag and FSM.
   always_comb begin
      pending_d = pending_q;
      if (wb_hit) pending_d[wb_dest] = 1'b0;
      if (set_pend) pending_d[dec_dest] = 1'b1;

      out_cnt_d = out_cnt_q + CNT_W'(set_pend) - CNT_W'(wb_hit);

      wb_err_d = wb_err_q | (wb_valid & ~wb_hit & (wb_dest != '0));

      // RAW/WAW hold has priority over the full-queue hold.
      if ((raw | waw) & ~flush)   state_d = ST_HOLD_RAW;
      else if (full & ~flush)     state_d = ST_HOLD_FULL;
      else                        state_d = ST_RUN;
   end

   // State registers, cleared asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         out_cnt_q <= '0;
         state_q   <= ST_RUN;
         wb_err_q  <= 1'b0;
      end else begin
         pending_q <= pending_d;
         out_cnt_q <= out_cnt_d;
         state_q   <= state_d;
         wb_err_q  <= wb_err_d;
      end
   end

   assign pending = pending_q;
   assign out_cnt = out_cnt_q;
   assign state   = state_q;
   assign wb_err  = wb_err_q;

`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles_q, stall_cycles_d;

   // Saturating count of stalled cycles.
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) stall_cycles_d = stall_cycles_q + 32'd1;
   end

   // Stall statistics register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cycles_q <= '0;
      else        stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;
`endif

`ifndef SYNTHESIS
   // The outstanding count must always equal the number of pending bits.
   a_cnt_consistent : assert property (@(posedge clk) disable iff (!rst_n)
      (int'(out_cnt_q) == $countones(pending_q)) && (int'(out_cnt_q) <= MAX_OUT));
`endif

endmodule

// File: tb/tb_vec_hazard_scoreboard.sv
// tb_vec_hazard_scoreboard
//   Directed bench. The driver applies one input vector per cycle and pushes
//   the hand-computed expected outputs; a monitor on the falling edge pops and
//   compares. Build with HAZARD_STATS_EN to also check stall_cycles.
module tb_vec_hazard_scoreboard;

   localparam int W = 25;

   logic        clk;
   logic        rst_n;
   logic        dec_valid;
   logic [3:0]  dec_r2, dec_r3, dec_dest, wb_dest;
   logic [1:0]  dec_extndsel;
   logic        dec_is_load, flush, wb_valid;
   logic        stall, bubble, issue, wb_err;
   logic [15:0] pending;
   logic [2:0]  out_cnt;
   logic [1:0]  state;
`ifdef HAZARD_STATS_EN
   logic [31:0] stall_cycles;
`endif

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           n_checks;
   int           n_fails;

   vec_hazard_scoreboard dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .dec_valid    (dec_valid),
      .dec_r2       (dec_r2),
      .dec_r3       (dec_r3),
      .dec_extndsel (dec_extndsel),
      .dec_is_load  (dec_is_load),
      .dec_dest     (dec_dest),
      .flush        (flush),
      .wb_valid     (wb_valid),
      .wb_dest      (wb_dest),
      .stall        (stall),
      .bubble       (bubble),
      .issue        (issue),
      .pending      (pending),
      .out_cnt      (out_cnt),
      .state        (state),
`ifdef HAZARD_STATS_EN
      .stall_cycles (stall_cycles),
`endif
      .wb_err       (wb_err)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of stimulus just after the rising edge.
   task automatic drive(input logic v, input logic [1:0] sel, input logic [3:0] r2,
                        input logic [3:0] r3, input logic ld, input logic [3:0] dest,
                        input logic fl, input logic wv, input logic [3:0] wd);
      @(posedge clk);
      #1;
      dec_valid    = v;
      dec_extndsel = sel;
      dec_r2       = r2;
      dec_r3       = r3;
      dec_is_load  = ld;
      dec_dest     = dest;
      flush        = fl;
      wb_valid     = wv;
      wb_dest      = wd;
   endtask

   task automatic idle();
      drive(1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0);
   endtask

   // Expected outputs for the cycle just driven (bubble always equals stall).
   task automatic expect_out(input string nm, input logic st, input logic iss,
                             input logic [15:0] pend, input logic [2:0] cnt,
                             input logic [1:0] fsm, input logic err);
      exp_q.push_back({st, st, iss, pend, cnt, fsm, err});
      name_q.push_back(nm);
   endtask

   // Monitor: compare on the falling edge whenever an expectation is queued.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [W-1:0] e;
         logic [W-1:0] a;
         string        nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         a  = {stall, bubble, issue, pending, out_cnt, state, wb_err};
         n_checks++;
         if (a !== e) begin
            n_fails++;
            $display("FAIL %s: got stall/bub/iss=%b%b%b pend=%h cnt=%0d st=%b err=%b, expected %b%b%b pend=%h cnt=%0d st=%b err=%b",
                     nm, a[24], a[23], a[22], a[21:6], a[5:3], a[2:1], a[0],
                     e[24], e[23], e[22], e[21:6], e[5:3], e[2:1], e[0]);
         end
      end
   end

   initial begin
      n_checks = 0;
      n_fails  = 0;
      rst_n    = 1'b0;
      dec_valid = 0; dec_extndsel = 0; dec_r2 = 0; dec_r3 = 0;
      dec_is_load = 0; dec_dest = 0; flush = 0; wb_valid = 0; wb_dest = 0;

      // Reset state
      idle();
      expect_out("reset", 0, 0, 16'h0000, 3'd0, 2'b00, 0);
      idle();
      rst_n = 1'b1;

      // 1: plain ALU op after reset
      drive(1, 2'b00, 4'd5, 4'd6, 0, 4'd0, 0, 0, 4'd0);
      expect_out("s1_no_hazard", 0, 1, 16'h0000, 3'd0, 2'b00, 0);

      // 2: load R5 then use it
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd5, 0, 0, 4'd0);
      expect_out("s2_issue_load5", 0, 1, 16'h0000, 3'd0, 2'b00, 0);
      drive(1, 2'b01, 4'd5, 4'd0, 0, 4'd0, 0, 0, 4'd0);
      expect_out("s2_raw_stall", 1, 0, 16'h0020, 3'd1, 2'b00, 0);
      drive(1, 2'b01, 4'd5, 4'd0, 0, 4'd0, 0, 0, 4'd0);
      expect_out("s2_hold_raw", 1, 0, 16'h0020, 3'd1, 2'b01, 0);
      drive(1, 2'b01, 4'd5, 4'd0, 0, 4'd0, 0, 1, 4'd5);
      expect_out("s2_wb_forward", 0, 1, 16'h0020, 3'd1, 2'b01, 0);
      idle();
      expect_out("s2_cleared", 0, 0, 16'h0000, 3'd0, 2'b00, 0);

      // 3: operand usage by extndsel
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd6, 0, 0, 4'd0);
      expect_out("s3_issue_load6", 0, 1, 16'h0000, 3'd0, 2'b00, 0);
      drive(1, 2'b01, 4'd5, 4'd6, 0, 4'd0, 0, 0, 4'd0);
      expect_out("s3_r3_unused", 0, 1, 16'h0040, 3'd1, 2'b00, 0);
      drive(1, 2'b00, 4'd5, 4'd6, 0, 4'd0, 0, 0, 4'd0);
      expect_out("s3_r3_used", 1, 0, 16'h0040, 3'd1, 2'b00, 0);
      drive(1, 2'b11, 4'd5, 4'd6, 0, 4'd0, 0, 0, 4'd0);
      expect_out("s3_immediate", 0, 1, 16'h0040, 3'd1, 2'b01, 0);
      drive(0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd6);
      expect_out("s3_wb6", 0, 0, 16'h0040, 3'd1, 2'b00, 0);

      // 4: fill the outstanding-load limit
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd1, 0, 0, 4'd0);
      expect_out("s4_load1", 0, 1, 16'h0000, 3'd0, 2'b00, 0);
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd2, 0, 0, 4'd0);
      expect_out("s4_load2", 0, 1, 16'h0002, 3'd1, 2'b00, 0);
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd3, 0, 0, 4'd0);
      expect_out("s4_load3", 0, 1, 16'h0006, 3'd2, 2'b00, 0);
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd4, 0, 0, 4'd0);
      expect_out("s4_load4", 0, 1, 16'h000E, 3'd3, 2'b00, 0);
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd7, 0, 0, 4'd0);
      expect_out("s4_full_stall", 1, 0, 16'h001E, 3'd4, 2'b00, 0);
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd7, 0, 0, 4'd0);
      expect_out("s4_hold_full", 1, 0, 16'h001E, 3'd4, 2'b10, 0);
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd7, 0, 1, 4'd2);
      expect_out("s4_wb2_frees_slot", 0, 1, 16'h001E, 3'd4, 2'b10, 0);
      idle();
      expect_out("s4_set_and_clear", 0, 0, 16'h009A, 3'd4, 2'b00, 0);

      // 5: WAW on R3 (also full; RAW/WAW hold wins), then flush
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd3, 0, 0, 4'd0);
      expect_out("s5_waw_stall", 1, 0, 16'h009A, 3'd4, 2'b00, 0);
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd3, 1, 0, 4'd0);
      expect_out("s5_flush", 0, 0, 16'h009A, 3'd4, 2'b01, 0);
      idle();
      expect_out("s5_after_flush", 0, 0, 16'h009A, 3'd4, 2'b00, 0);
`ifdef HAZARD_STATS_EN
      @(negedge clk);
      n_checks++;
      if (stall_cycles !== 32'd6) begin
         n_fails++;
         $display("FAIL stall_cycles: got %0d expected 6", stall_cycles);
      end
`endif

      // Drain the remaining loads
      drive(0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd1);
      expect_out("drain_wb1", 0, 0, 16'h009A, 3'd4, 2'b00, 0);
      drive(0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd3);
      expect_out("drain_wb3", 0, 0, 16'h0098, 3'd3, 2'b00, 0);
      drive(0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd4);
      expect_out("drain_wb4", 0, 0, 16'h0090, 3'd2, 2'b00, 0);
      drive(0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd7);
      expect_out("drain_wb7", 0, 0, 16'h0080, 3'd1, 2'b00, 0);
      idle();
      expect_out("drained", 0, 0, 16'h0000, 3'd0, 2'b00, 0);

      // 6: stray write-back and load to R0
      drive(0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd9);
      expect_out("s6_stray_wb", 0, 0, 16'h0000, 3'd0, 2'b00, 0);
      idle();
      expect_out("s6_wb_err_set", 0, 0, 16'h0000, 3'd0, 2'b00, 1);
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd0, 0, 0, 4'd0);
      expect_out("s6_load_r0", 0, 1, 16'h0000, 3'd0, 2'b00, 1);
      idle();
      expect_out("s6_r0_untracked", 0, 0, 16'h0000, 3'd0, 2'b00, 1);

      // 7: reset mid-operation, then a stale write-back
      drive(1, 2'b10, 4'd0, 4'd0, 1, 4'd8, 0, 0, 4'd0);
      expect_out("s7_load8", 0, 1, 16'h0000, 3'd0, 2'b00, 1);
      idle();
      expect_out("s7_pending8", 0, 0, 16'h0100, 3'd1, 2'b00, 1);
      idle();
      rst_n = 1'b0;
      expect_out("s7_async_reset", 0, 0, 16'h0000, 3'd0, 2'b00, 0);
      drive(0, 2'b00, 4'd0, 4'd0, 0, 4'd0, 0, 1, 4'd8);
      rst_n = 1'b1;
      expect_out("s7_stale_wb", 0, 0, 16'h0000, 3'd0, 2'b00, 0);
      idle();
      expect_out("s7_stale_err", 0, 0, 16'h0000, 3'd0, 2'b00, 1);

      // Let the monitor consume the last entry, then confirm nothing was left.
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fails++;
         $display("FAIL queue_empty: got %0d entries left, expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
